// File: rtl/inst_loader_pkg.sv
// Shared processor definitions used by the instruction loader.
package inst_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/inst_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian words and writes them.
// Define INST_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_rst_hold
);

  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W     = (AW+1)'(1);
  localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [AW:0] word_cnt;
  logic [AW:0] last_word;
  logic [23:0] word_buf;
  logic        accept;
  logic        len_ok;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign accept = byte_valid && byte_ready;
  assign len_ok = (len != '0) && (len <= DEPTH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      last_word    <= '0;
      word_buf     <= '0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_rst_hold <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cpu_rst_hold <= 1'b1;
            if (len_ok) begin
              state      <= LOAD;
              done       <= 1'b0;
              error      <= 1'b0;
              byte_cnt   <= '0;
              word_cnt   <= '0;
              last_word  <= len - ONE_W;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
              sum        <= '0;
`endif
            end else begin
              state      <= DONE;
              done       <= 1'b1;
              error      <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
`ifdef INST_LOADER_CHECKSUM_EN
            sum <= sum + byte_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
              // The 4th byte goes straight into the write data, so the
              // write lands one cycle after its handshake with no stall.
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[AW-1:0];
              mem_wdata <= {byte_data, word_buf};
              byte_cnt  <= '0;
              word_cnt  <= word_cnt + ONE_W;
              if (word_cnt == last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state        <= CHECK;
`else
                state        <= DONE;
                busy         <= 1'b0;
                byte_ready   <= 1'b0;
                done         <= 1'b1;
                cpu_rst_hold <= 1'b0;
`endif
              end
            end else begin
              case (byte_cnt)
                2'd0:    word_buf[7:0]   <= byte_data;
                2'd1:    word_buf[15:8]  <= byte_data;
                default: word_buf[23:16] <= byte_data;
              endcase
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            state        <= DONE;
            busy         <= 1'b0;
            byte_ready   <= 1'b0;
            done         <= 1'b1;
            error        <= (byte_data != sum);
            cpu_rst_hold <= (byte_data != sum);
          end
        end
`endif
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a byte-stream reference model.
module tb_inst_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start      = 1'b0;
  logic [AW:0]   len        = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data  = '0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_rst_hold;

  int tests = 0;
  int fails = 0;

  int          got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  byte_q[$];

  int            stab_bad = 0;
  bit            rst_flag = 1'b0;
  logic [AW-1:0] pa = '0;
  logic [31:0]   pd = '0;

  inst_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_rst_hold(cpu_rst_hold)
  );

  always #5 clk = ~clk;

  always @(posedge rst) rst_flag = 1'b1;

  // Write monitor: records every write strobe and watches address/data hold.
  always begin
    @(posedge clk);
    #1;
    if (mem_we) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(mem_wdata);
    end else if (!rst && !rst_flag && (mem_addr !== pa || mem_wdata !== pd)) begin
      stab_bad++;
    end
    rst_flag = 1'b0;
    pa = mem_addr;
    pd = mem_wdata;
  end

  task automatic fill_random(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic prep_ck(input bit corrupt);
    int s;
    s = 0;
    if (CK != 0) begin
      foreach (byte_q[i]) s = (s + int'(byte_q[i])) % 256;
      if (corrupt) s = (s + 1) % 256;
      byte_q.push_back(8'(s));
    end
  endtask

  // gap: 0 = continuous, 1 = valid every other cycle, 2 = random.
  // start_at >= 0 pulses start (with a different len) just before that byte.
  task automatic run_load(input int ln, input int gap, input int start_at, input bit exp_err);
    int  nb, idx, cyc, base, exp_words, bad, wexp;
    bit  valid_len, seq_err, tog, v, pulsed;
    logic [31:0] w;
    valid_len = (ln >= 1) && (ln <= DEPTH);
    nb        = valid_len ? ln * 4 + CK : 0;
    exp_words = valid_len ? ln : 0;
    base      = got_addr.size();

    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(ln);
    @(negedge clk);
    start = 1'b0;
    if (valid_len) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || cpu_rst_hold !== 1'b1)
        $display("FAIL load_begin: busy=%b done=%b hold=%b want 1 0 1", busy, done, cpu_rst_hold);
      if (busy !== 1'b1 || done !== 1'b0 || cpu_rst_hold !== 1'b1) fails++;
    end

    idx = 0; cyc = 0; tog = 1'b0; seq_err = 1'b0; pulsed = 1'b0;
    while (idx < nb && cyc < 4000) begin
      wexp = (idx / 4 < ln) ? idx / 4 : ln;
      if (got_addr.size() - base != wexp) seq_err = 1'b1;
      case (gap)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      byte_valid = v;
      byte_data  = byte_q[idx];
      if (!pulsed && idx == start_at) begin
        start  = 1'b1;
        len    = (AW+1)'(1);
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (v && byte_ready === 1'b1) idx++;
      cyc++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    start      = 1'b0;

    if (nb > 0) begin
      tests++;
      if (idx != nb) begin
        fails++;
        $display("FAIL byte_budget: accepted %0d bytes want %0d", idx, nb);
      end
      tests++;
      if (seq_err) begin
        fails++;
        $display("FAIL write_timing: write seen before its 4th byte (len %0d)", ln);
      end
      if (gap == 0) begin
        tests++;
        if (cyc != nb) begin
          fails++;
          $display("FAIL throughput: %0d cycles want %0d", cyc, nb);
        end
      end
    end

    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (done !== 1'b1 || error !== exp_err) begin
      fails++;
      $display("FAIL done_error: done=%b error=%b want 1 %b", done, error, exp_err);
    end
    tests++;
    if (cpu_rst_hold !== exp_err || busy !== 1'b0 || byte_ready !== 1'b0) begin
      fails++;
      $display("FAIL end_state: hold=%b busy=%b ready=%b want %b 0 0", cpu_rst_hold, busy, byte_ready, exp_err);
    end
    tests++;
    if (got_addr.size() - base != exp_words) begin
      fails++;
      $display("FAIL write_count: got %0d want %0d", got_addr.size() - base, exp_words);
    end else if (exp_words > 0) begin
      bad = 0;
      for (int i = 0; i < exp_words; i++) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++) w = w + 32'(byte_q[4*i+k]) * (32'd1 << (8*k));
        if (got_addr[base+i] != i || got_data[base+i] !== w) begin
          if (bad == 0)
            $display("FAIL write_data: word %0d got addr %0d data %08h want addr %0d data %08h",
                     i, got_addr[base+i], got_data[base+i], i, w);
          bad++;
        end
      end
      if (bad != 0) fails++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b we=%b busy=%b done=%b err=%b want all 0",
               byte_ready, mem_we, busy, done, error);
    end
    tests++;
    if (mem_addr !== '0 || mem_wdata !== 32'd0 || cpu_rst_hold !== 1'b1) begin
      fails++;
      $display("FAIL reset_data: addr=%0h data=%08h hold=%b want 0 0 1", mem_addr, mem_wdata, cpu_rst_hold);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || byte_ready !== 1'b0 || cpu_rst_hold !== 1'b1) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b ready=%b hold=%b want 0 0 1", busy, byte_ready, cpu_rst_hold);
    end
  endtask

  task automatic test_directed();
    int base;
    byte_q = '{8'h13, 8'h01, 8'h81, 8'h00, 8'hB3, 8'h01, 8'h01, 8'h00};
    prep_ck(1'b0);
    base = got_addr.size();
    run_load(2, 0, -1, 1'b0);
    tests++;
    if (got_data.size() < base + 2) begin
      fails++;
      $display("FAIL directed_words: got %0d writes want 2", got_data.size() - base);
    end else if (got_data[base] !== 32'h00810113 || got_data[base+1] !== 32'h000101B3) begin
      fails++;
      $display("FAIL directed_words: got %08h %08h want 00810113 000101b3", got_data[base], got_data[base+1]);
    end
  endtask

  task automatic test_bad_len();
    int base;
    byte_q.delete();
    run_load(0, 0, -1, 1'b1);
    run_load(DEPTH + 1, 0, -1, 1'b1);
    base = got_addr.size();
    for (int i = 0; i < 6; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    byte_valid = 1'b0;
    tests++;
    if (got_addr.size() != base || byte_ready !== 1'b0 || error !== 1'b1) begin
      fails++;
      $display("FAIL bad_len_idle: writes=%0d ready=%b err=%b want 0 0 1", got_addr.size() - base, byte_ready, error);
    end
  endtask

  task automatic test_gapped();
    int base;
    byte_q = '{8'h03, 8'h00, 8'h00, 8'h00};
    prep_ck(1'b0);
    base = got_addr.size();
    run_load(1, 1, -1, 1'b0);
    tests++;
    if (got_data.size() != base + 1 || got_data[base] !== 32'h00000003) begin
      fails++;
      $display("FAIL gapped_word: writes=%0d want 1 of 00000003", got_data.size() - base);
    end
  endtask

  task automatic test_reset_abort();
    int base;
    base = got_addr.size();
    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(3);
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    @(negedge clk);
    byte_data  = 8'h55;
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'd0 || cpu_rst_hold !== 1'b1) begin
      fails++;
      $display("FAIL abort_outputs: busy=%b ready=%b done=%b err=%b we=%b addr=%0h data=%08h hold=%b",
               busy, byte_ready, done, error, mem_we, mem_addr, mem_wdata, cpu_rst_hold);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (got_addr.size() != base) begin
      fails++;
      $display("FAIL abort_no_write: got %0d writes want 0", got_addr.size() - base);
    end
    fill_random(8);
    prep_ck(1'b0);
    run_load(2, 0, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    fill_random(12);
    prep_ck(1'b0);
    run_load(3, 0, 5, 1'b0);
    fill_random(16);
    prep_ck(1'b0);
    run_load(4, 2, 9, 1'b0);
  endtask

  task automatic test_random();
    int ln;
    for (int t = 0; t < 6; t++) begin
      ln = $urandom_range(1, 6);
      fill_random(ln * 4);
      prep_ck(1'b0);
      run_load(ln, t % 3, -1, 1'b0);
    end
    fill_random(DEPTH * 4);
    prep_ck(1'b0);
    run_load(DEPTH, 0, -1, 1'b0);
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_load(1, 0, -1, 1'b0);
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_load(1, 0, -1, 1'b1);
  endtask
`endif

  task automatic test_stability();
    tests++;
    if (stab_bad != 0) begin
      fails++;
      $display("FAIL addr_data_hold: %0d changes without mem_we want 0", stab_bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_len();
    test_gapped();
    test_reset_abort();
    test_start_ignored();
    test_random();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_stability();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit instruction-memory words.
REQ-002 SHALL have parameter AW, default 6, word-address width, with 2^AW >= DEPTH.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load.
REQ-006 SHALL have port len, input, AW+1, number of words to load, sampled on start.
REQ-007 SHALL have port byte_valid, input, 1, source byte present.
REQ-008 SHALL have port byte_data, input, 8, source byte.
REQ-009 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we, output, 1, instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port mem_addr, output, AW, word address of the write.
REQ-012 SHALL have port mem_wdata, output, 32, instruction word.
REQ-013 SHALL have port busy, output, 1, load in progress.
REQ-014 SHALL have port done, output, 1, level, load finished; held until next accepted start.
REQ-015 SHALL have port error, output, 1, level, bad len or checksum mismatch; valid while done=1.
REQ-016 SHALL have port cpu_rst_hold, output, 1, holds the processor in reset until a good load.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CHECK, DONE.
REQ-018 SHALL count a byte as transferred only in a cycle with byte_valid=1 and byte_ready=1.
REQ-019 SHALL drive byte_ready=1 only in LOAD and CHECK, independent of byte_valid.
REQ-020 SHALL, in IDLE or DONE, on start with 1 <= len <= DEPTH, clear done/error, zero byte and word counters, enter LOAD.
REQ-021 SHALL, on start with len=0 or len>DEPTH, enter DONE with error=1 and perform no writes.
REQ-022 SHALL ignore start while in LOAD or CHECK.
REQ-023 SHALL assemble bytes little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-024 SHALL assert mem_we for exactly one cycle, in the cycle after the 4th-byte handshake, with mem_addr = word index (0 first) and mem_wdata = assembled word.
REQ-025 SHALL keep byte_ready=1 during a mem_we cycle so back-to-back bytes sustain one byte per clock.
REQ-026 SHALL, on the 4th-byte handshake of word len-1, leave LOAD (to CHECK if checksum enabled, else DONE); that word's mem_we is the cycle DONE or CHECK is first entered.
REQ-027 SHALL hold mem_addr and mem_wdata stable when mem_we=0 and never write addresses >= len.
REQ-028 SHALL drive busy=1 exactly in LOAD and CHECK.
REQ-029 SHALL drive cpu_rst_hold=0 only in DONE with error=0; 1 otherwise, including during any reload.

Reset
REQ-030 SHALL on rst=1 immediately enter IDLE, abort any partial word without writing it, and force byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_rst_hold=1.

Configuration
REQ-031 SHALL, with INST_LOADER_CHECKSUM_EN defined, in CHECK accept one byte and compare it with the 8-bit modulo-256 sum of all loaded bytes; mismatch sets error=1; then enter DONE.
REQ-032 SHALL, without INST_LOADER_CHECKSUM_EN, never enter CHECK, contain no sum logic, and set error only per REQ-021.

Structure
REQ-033 SHALL take the FSM state enum and constant WORD_BYTES=4 from the shared processor package.
REQ-034 SHALL be one module with no sub-modules; the byte-to-word assembler stays inline.

Verification
REQ-035 SHALL cover: start, len=2, bytes 13 01 81 00 B3 01 01 00 back-to-back -> mem_we at addr 0 data 0x00810113, then addr 1 data 0x000101B3; done=1, cpu_rst_hold=0.
REQ-036 SHALL cover: start, len=0 and len=65 -> done=1, error=1, no mem_we, cpu_rst_hold=1.
REQ-037 SHALL cover: len=1, byte_valid toggled every other cycle -> single write 0x00000003 for bytes 03 00 00 00, after the 4th accepted byte only.
REQ-038 SHALL cover: rst pulsed after 2 bytes of word 0 -> no mem_we, IDLE, outputs at reset values; a fresh load then succeeds.
REQ-039 SHALL cover (CHECKSUM_EN): len=1, bytes 01 02 03 04 then 0A -> error=0; then 0B -> error=1, cpu_rst_hold=1.
REQ-040 SHALL cover: start pulsed mid-LOAD -> ignored, counters and addresses unaffected.
